demux_rr_sequencer: RTL and testbench



---
 rtl/demux_pkg.sv | 29 ++
 rtl/rr_pick4.sv | 31 +++
 rtl/demux_rr_sequencer.sv | 134 +++++++++++++
 tb/tb_demux_rr_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the round-robin demux channel sequencer.
// Holds the FSM state encoding, channel count, select width and a small
// one-hot helper used to build the per-channel acknowledge.

package demux_pkg;

  // Number of demux outputs / request channels
  localparam int NUM_CH = 4;

  // Width of the demux select bus
  localparam int SEL_W = 2;

  // Sequencer states; GAP is only reachable when the break-before-make
  // feature is compiled in
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // One-hot vector with only bit 'ch' set
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [SEL_W-1:0] ch);
    logic [NUM_CH-1:0] v;
    v     = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: purely combinational round-robin picker for four requesters.
// The search starts at the channel after 'last' and wraps around, so the
// most recently served channel has the lowest priority.

module rr_pick4
  import demux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic              valid,
  output logic [SEL_W-1:0]  idx
);

  logic [SEL_W-1:0] ch;

  // Walk from the farthest candidate (last itself) to the nearest (last+1);
  // the final hit therefore belongs to the highest-priority requester
  always_comb begin
    valid = 1'b0;
    idx   = last;
    ch    = last;
    for (int i = NUM_CH; i >= 1; i--) begin
      ch = last + SEL_W'(i);
      if (req[ch]) begin
        valid = 1'b1;
        idx   = ch;
      end
    end
  end

endmodule

// File: rtl/demux_rr_sequencer.sv
// demux_rr_sequencer: round-robin channel sequencer feeding a 4-output demux.
// Grants one requesting channel at a time, holds the demux select on it for
// DWELL cycles while routing the registered serial bit, and pulses a
// one-cycle per-channel ack when a dwell completes.
// Optional feature: define DEMUX_SEQ_GAP_EN to insert one enable-low GAP
// cycle after every grant so the demux select never moves while enabled.

module demux_rr_sequencer
  import demux_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = $clog2(DWELL + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              din,
  output logic [SEL_W-1:0]  sel,
  output logic              en,
  output logic              dout,
  output logic [NUM_CH-1:0] ack,
  output logic              busy
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SEL_W-1:0] last, last_n;
  logic [SEL_W-1:0] sel_q, sel_n;
  logic             dout_q;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic             do_arb;
  logic             grant_done;

  rr_pick4 u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // A grant ends either on dwell completion or when its requester lets go;
  // completion takes precedence only in that it drives the ack
  assign grant_done = (cnt == '0) || !req[sel_q];

  // State, counter, round-robin pointer and select registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      last  <= SEL_W'(NUM_CH - 1);
      sel_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      last  <= last_n;
      sel_q <= sel_n;
    end
  end

  // Next-state logic: dwell countdown, release, and re-arbitration
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    sel_n   = sel_q;
    do_arb  = 1'b0;

    case (state)
      ST_IDLE: begin
        do_arb = 1'b1;
      end

      ST_GRANT: begin
        if (grant_done) begin
`ifdef DEMUX_SEQ_GAP_EN
          state_n = ST_GAP;
          cnt_n   = '0;
`else
          do_arb  = 1'b1;
`endif
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

`ifdef DEMUX_SEQ_GAP_EN
      ST_GAP: begin
        do_arb = 1'b1;
      end
`endif

      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    if (do_arb) begin
      if (pick_valid) begin
        state_n = ST_GRANT;
        sel_n   = pick_idx;
        last_n  = pick_idx;
        cnt_n   = CNT_W'(DWELL - 1);
      end else begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    end
  end

  // Serial data is captured only when the next cycle is an enabled grant,
  // so the demux data input is zero whenever the enable is low
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= 1'b0;
    end else begin
      dout_q <= (state_n == ST_GRANT) ? din : 1'b0;
    end
  end

  // Outputs decoded purely from registered state (no input-to-output path)
  always_comb begin
    sel  = sel_q;
    en   = (state == ST_GRANT);
    busy = (state != ST_IDLE);
    dout = dout_q;
    ack  = '0;
    if ((state == ST_GRANT) && (cnt == '0)) begin
      ack = ch_onehot(sel_q);
    end
  end

endmodule

// File: tb/tb_demux_rr_sequencer.sv
// tb_demux_rr_sequencer: directed, table-driven bench for demux_rr_sequencer.
// One instance uses DWELL=4 and is driven from a vector table; a second
// instance uses DWELL=1 and is driven by a short hand-written sequence.
// Expectations follow DEMUX_SEQ_GAP_EN when it is defined.

module tb_demux_rr_sequencer;

  logic       clk = 1'b0;
  logic       rst, din, rst1, din1;
  logic [3:0] req, req1;
  logic [1:0] sel, sel1;
  logic       en, en1, dout, dout1, busy, busy1;
  logic [3:0] ack, ack1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       din;
    logic [1:0] sel;
    logic       en;
    logic       dout;
    logic [3:0] ack;
    logic       busy;
    string      name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  demux_rr_sequencer #(.DWELL(4)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .din  (din),
    .sel  (sel),
    .en   (en),
    .dout (dout),
    .ack  (ack),
    .busy (busy)
  );

  demux_rr_sequencer #(.DWELL(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst1),
    .req  (req1),
    .din  (din1),
    .sel  (sel1),
    .en   (en1),
    .dout (dout1),
    .ack  (ack1),
    .busy (busy1)
  );

  function automatic logic [3:0] oh(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  // Append one vector: inputs applied before an edge, outputs expected after it
  function automatic void add(input logic r, input logic [3:0] rq, input logic [1:0] s,
                              input logic e, input logic [3:0] a, input logic b,
                              input string nm);
    vec_t v;
    v.rst  = r;
    v.req  = rq;
    v.din  = ((vecs.size() % 2) == 1);
    v.sel  = s;
    v.en   = e;
    v.dout = e & v.din;
    v.ack  = a;
    v.busy = b;
    v.name = nm;
    vecs.push_back(v);
  endfunction

  // Requests removed after a completed or released grant on channel s
  function automatic void go_idle(input logic [1:0] s);
`ifdef DEMUX_SEQ_GAP_EN
    add(1'b0, 4'b0000, s, 1'b0, 4'b0000, 1'b1, "gap_to_idle");
`endif
    add(1'b0, 4'b0000, s, 1'b0, 4'b0000, 1'b0, "idle");
  endfunction

  function automatic void build_table();
    // reset with all requests held
    add(1'b1, 4'b1111, 2'd0, 1'b0, 4'b0000, 1'b0, "reset");
    add(1'b1, 4'b1111, 2'd0, 1'b0, 4'b0000, 1'b0, "reset");
    // continuous requests: grant order 0,1,2,3,0
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        add(1'b0, 4'b1111, 2'(g % 4), 1'b1, (c == 3) ? oh(2'(g % 4)) : 4'b0000, 1'b1, "rr");
      end
`ifdef DEMUX_SEQ_GAP_EN
      if (g < 4) add(1'b0, 4'b1111, 2'(g % 4), 1'b0, 4'b0000, 1'b1, "rr_gap");
`endif
    end
    go_idle(2'd0);
    // single requester on channel 2
    for (int c = 0; c < 4; c++) begin
      add(1'b0, 4'b0100, 2'd2, 1'b1, (c == 3) ? 4'b0100 : 4'b0000, 1'b1, "ch2");
    end
    go_idle(2'd2);
    // early release of channel 1 on its second dwell cycle
    add(1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b1, "rel_c1");
    add(1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b1, "rel_c2");
`ifdef DEMUX_SEQ_GAP_EN
    add(1'b0, 4'b0101, 2'd1, 1'b0, 4'b0000, 1'b1, "rel_gap");
`endif
    add(1'b0, 4'b0101, 2'd2, 1'b1, 4'b0000, 1'b1, "rel_next");
    go_idle(2'd2);
    // reset on the third dwell cycle of channel 3
    for (int c = 0; c < 3; c++) add(1'b0, 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b1, "ch3");
    add(1'b1, 4'b1000, 2'd0, 1'b0, 4'b0000, 1'b0, "rst_mid");
    for (int c = 0; c < 4; c++) begin
      add(1'b0, 4'b1000, 2'd3, 1'b1, (c == 3) ? 4'b1000 : 4'b0000, 1'b1, "fresh3");
    end
    go_idle(2'd3);
  endfunction

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    rst = v.rst;
    req = v.req;
    din = v.din;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string nm, input int idx, input logic [8:0] got,
                              input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got {sel,en,dout,ack,busy}=%b expected %b", nm, idx, got, exp);
    end
  endtask

  initial begin
    logic [1:0] s1;
    logic       d1;
    rst  = 1'b1;
    req  = 4'b0000;
    din  = 1'b0;
    rst1 = 1'b1;
    req1 = 4'b0000;
    din1 = 1'b0;

    build_table();
    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i].name, i, {sel, en, dout, ack, busy},
                   {vecs[i].sel, vecs[i].en, vecs[i].dout, vecs[i].ack, vecs[i].busy});
    end

    // DWELL=1 instance: single-cycle grants alternating between 0 and 1
    @(negedge clk);
    rst1 = 1'b1;
    req1 = 4'b0011;
    @(posedge clk);
    #1;
    check_output("d1_reset", 0, {sel1, en1, dout1, ack1, busy1}, 9'b0);
    s1 = 2'd0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rst1 = 1'b0;
      d1   = (k % 2) == 0;
      din1 = d1;
      @(posedge clk);
      #1;
`ifdef DEMUX_SEQ_GAP_EN
      s1 = 2'((k / 2) % 2);
      if ((k % 2) == 0)
        check_output("d1_grant", k, {sel1, en1, dout1, ack1, busy1}, {s1, 1'b1, d1, oh(s1), 1'b1});
      else
        check_output("d1_gap", k, {sel1, en1, dout1, ack1, busy1}, {s1, 1'b0, 1'b0, 4'b0000, 1'b1});
`else
      s1 = 2'(k % 2);
      check_output("d1_grant", k, {sel1, en1, dout1, ack1, busy1}, {s1, 1'b1, d1, oh(s1), 1'b1});
`endif
    end
    @(negedge clk);
    req1 = 4'b0000;
    din1 = 1'b1;
    @(posedge clk);
    #1;
    check_output("d1_idle", 0, {sel1, en1, dout1, ack1, busy1}, {s1, 1'b0, 1'b0, 4'b0000, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
